// File: rtl/lr3_disp_scan_if.sv
// Display bus between the LR3 sequential-logic block (producer) and the 7-segment scanner.
interface lr3_disp_scan_if;
  logic [31:0] DISP_SEQ;
  logic [7:0]  DISP_OFF;
  logic [7:0]  DISP_DP;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        FRAME;

  modport master (
    output DISP_SEQ, DISP_OFF, DISP_DP,
    input  AN, SEG, DP, FRAME
  );

  modport slave (
    input  DISP_SEQ, DISP_OFF, DISP_DP,
    output AN, SEG, DP, FRAME
  );
endinterface

// File: rtl/lr3_disp_scan.sv
// 8-digit common-anode 7-segment scanner; inputs snapshotted once per frame, outputs registered
// (1-cycle lag behind the slot counter); free-running, no backpressure.
module lr3_disp_scan #(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 2000
) (
  input  logic           CLK,
  input  logic           RST,
  lr3_disp_scan_if.slave bus
);
  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;
  logic [2:0]    dig;
  logic [31:0]   snap_seq;
  logic [7:0]    snap_off;
  logic [7:0]    snap_dp;
  logic [7:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic          frame_q;

  logic          slot_end;
  logic          snap_ld;
  logic          lit;
  logic [7:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign slot_end = (cnt == CW'(DIV - 1));
  // Snapshot lands in the blank part of digit 0, so no lit digit ever sees a half update.
  assign snap_ld  = (cnt == '0) && (dig == 3'd0);

  always_comb begin
    lit     = (cnt >= CW'(BLANK_CYC)) && !snap_off[dig];
    an_nxt  = 8'hFF;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (lit) begin
      an_nxt  = ~(8'd1 << dig);
      seg_nxt = hex7(snap_seq[{dig, 2'b00} +: 4]);
      dp_nxt  = ~snap_dp[dig];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt      <= '0;
      dig      <= 3'd0;
      snap_seq <= 32'h0;
      snap_off <= 8'hFF;
      snap_dp  <= 8'h00;
      an_q     <= 8'hFF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) begin
        dig <= dig + 3'd1;
      end
      if (snap_ld) begin
        snap_seq <= bus.DISP_SEQ;
        snap_off <= bus.DISP_OFF;
        snap_dp  <= bus.DISP_DP;
      end
      frame_q <= snap_ld;
      an_q    <= an_nxt;
      seg_q   <= seg_nxt;
      dp_q    <= dp_nxt;
    end
  end

  assign bus.AN    = an_q;
  assign bus.SEG   = seg_q;
  assign bus.DP    = dp_q;
  assign bus.FRAME = frame_q;
endmodule

// File: tb/tb_lr3_disp_scan.sv
// Scoreboard bench for lr3_disp_scan: directed frames, random input churn and async reset mid-slot.
module tb_lr3_disp_scan;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRM   = 8 * DIV;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
    int         t;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  lr3_disp_scan_if bus ();

  lr3_disp_scan #(.DIV(DIV), .BLANK_CYC(BLANK)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  bit          run   = 1'b0;
  int          t;
  logic [31:0] m_seq;
  logic [7:0]  m_off;
  logic [7:0]  m_dp;

  task automatic chk(input string name, input int tt, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0d got=%h expected=%h", name, tt, got, exp);
    end
  endtask

  // Reference: slot position derived from the edge number; display content from the last frame snapshot.
  task automatic step();
    exp_t e;
    int   c;
    int   d;
    bit   lit;
    c   = t % DIV;
    d   = (t / DIV) % 8;
    lit = (c >= BLANK) && !m_off[d];
    e.an    = lit ? ~(8'd1 << d) : 8'hFF;
    e.seg   = lit ? tbl[m_seq[4*d +: 4]] : 7'h7F;
    e.dp    = !(lit && m_dp[d]);
    e.frame = (t % FRM == 0);
    e.t     = t;
    q.push_back(e);
    if (t % FRM == 0) begin
      m_seq = bus.DISP_SEQ;
      m_off = bus.DISP_OFF;
      m_dp  = bus.DISP_DP;
    end
    t++;
    @(negedge CLK);
  endtask

  task automatic frames(input logic [31:0] s, input logic [7:0] o, input logic [7:0] p, input int n);
    bus.DISP_SEQ = s;
    bus.DISP_OFF = o;
    bus.DISP_DP  = p;
    repeat (n * FRM) step();
  endtask

  task automatic restart();
    t     = 0;
    m_seq = 32'h0;
    m_off = 8'hFF;
    m_dp  = 8'h00;
    RST   = 1'b0;
    run   = 1'b1;
  endtask

  always @(posedge CLK) begin
    #1;
    if (run && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("an", e.t, bus.AN, e.an);
      chk("seg", e.t, {1'b0, bus.SEG}, {1'b0, e.seg});
      chk("dp", e.t, {7'd0, bus.DP}, {7'd0, e.dp});
      chk("frame", e.t, {7'd0, bus.FRAME}, {7'd0, e.frame});
      chk("one_hot_an", e.t, 8'($countones(~bus.AN) <= 1), 8'd1);
    end
  end

  initial begin
    bus.DISP_SEQ = 32'h0;
    bus.DISP_OFF = 8'h00;
    bus.DISP_DP  = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_an", 0, bus.AN, 8'hFF);
    chk("rst_seg", 0, {1'b0, bus.SEG}, 8'h7F);
    chk("rst_dp", 0, {7'd0, bus.DP}, 8'd1);
    chk("rst_frame", 0, {7'd0, bus.FRAME}, 8'd0);
    @(negedge CLK);
    restart();

    frames(32'h87654321, 8'h00, 8'h00, 2);
    frames(32'h87654321, 8'hF0, 8'h00, 2);

    // Anti-tear: swap the data while digit 3 is lit; the model keeps the old snapshot.
    bus.DISP_SEQ = 32'h87654321;
    bus.DISP_OFF = 8'h00;
    repeat (3 * DIV + 2) step();
    bus.DISP_SEQ = 32'h00000000;
    repeat (FRM - 3 * DIV - 2) step();
    repeat (FRM) step();

    frames(32'hFEDCBA98, 8'h00, 8'h00, 1);
    frames(32'h76543210, 8'h00, 8'h00, 2);
    frames(32'h87654321, 8'h00, 8'h81, 2);
    frames(32'h87654321, 8'h01, 8'h01, 2);

    for (int i = 0; i < 20 * FRM; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.DISP_SEQ = $urandom;
        bus.DISP_OFF = 8'($urandom);
        bus.DISP_DP  = 8'($urandom);
      end
      step();
    end

    // Async reset while digit 2 is lit: blanking must not wait for a clock edge.
    frames(32'h87654321, 8'h00, 8'h00, 1);
    repeat (2 * DIV + 2) step();
    #1;
    chk("pre_rst_an", t, bus.AN, 8'hFB);
    run = 1'b0;
    q.delete();
    RST = 1'b1;
    #1;
    chk("async_an", t, bus.AN, 8'hFF);
    chk("async_seg", t, {1'b0, bus.SEG}, 8'h7F);
    chk("async_dp", t, {7'd0, bus.DP}, 8'd1);
    chk("async_frame", t, {7'd0, bus.FRAME}, 8'd0);
    repeat (2) @(negedge CLK);
    restart();
    frames(32'h13579BDF, 8'h24, 8'h42, 2);

    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lr3_disp_scan.md
Name: lr3_disp_scan

Overview:
Time-multiplexed scanner for the 8-digit common-anode 7-segment display. It is the reader side of the LR3 display bus: it consumes the DISP_SEQ/DISP_OFF words produced by the sequential-logic block and drives anodes, segments and the decimal point. Inputs are snapshotted once per frame, so a mid-frame update never tears the display.

Parameters:
DIV, 50000, clock cycles per digit slot; legal range 2..2^20.
BLANK_CYC, 2000, cycles at the start of each slot with all anodes off (ghosting guard); legal range 1..DIV-1.

Ports:
CLK  in  1  system clock; the only clock.
RST  in  1  reset, asynchronous, active-high.
DISP_SEQ  in  32  hex digits; digit i = DISP_SEQ[4i+3:4i], digit 0 rightmost.
DISP_OFF  in  8  bit i = 1 blanks digit i.
DISP_DP  in  8  bit i = 1 lights the decimal point of digit i.
AN  out  8  anodes, active-low, one-hot-low when a digit is shown.
SEG  out  7  segments, active-low, SEG[6:0] = g,f,e,d,c,b,a.
DP  out  1  decimal point, active-low.
FRAME  out  1  one-cycle pulse marking each snapshot load.

Behaviour:
- RST=1 forces these values immediately, without waiting for a clock edge: cnt=0, dig=0, snap_seq=0, snap_off=8'hFF, snap_dp=0, AN=8'hFF, SEG=7'h7F, DP=1, FRAME=0.
- Slot counter cnt: counts 0..DIV-1 and wraps to 0. The digit index dig (3 bit) increments whenever cnt==DIV-1, wrapping 7->0.
- Snapshot: in every cycle with cnt==0 && dig==0, snap_seq/snap_off/snap_dp load from DISP_SEQ/DISP_OFF/DISP_DP. This includes the first clock after reset release. Inputs are ignored at all other times.
- Slot state per cycle:
  - BLANK phase: cnt < BLANK_CYC.
  - SHOW phase: cnt >= BLANK_CYC.
- Output registers are computed from the current cnt, dig and snap values, and take effect at the clock edge. All outputs therefore lag the counter by exactly 1 cycle.
- AN next value:
  - 8'hFF in BLANK phase, or if snap_off[dig]=1.
  - Otherwise ~(8'b1 << dig).
- SEG next value:
  - 7'h7F whenever AN next value is 8'hFF.
  - Otherwise the hex decode of snap_seq nibble dig.
- DP next value: 0 only when AN shows digit dig and snap_dp[dig]=1; 1 otherwise.
- Hex decode (gfedcba, active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- FRAME: registered; high for the single cycle after each snapshot-load cycle.
- Because BLANK_CYC>=1, the snapshot cycle always falls in BLANK phase. Hence no digit ever shows a half-updated value.
- Frame period = 8*DIV cycles. Each digit is lit for DIV-BLANK_CYC cycles per frame.
- Invariant: at most one AN bit is low in any cycle.
- Reset asserted mid-slot: outputs blank at once. After release, scanning restarts at digit 0 with a fresh snapshot.
- No CE; the block free-runs. Input changes between snapshots have no visible effect until the next FRAME.

Test Plan:
(DIV=4, BLANK_CYC=1 for all scenarios)
1. Reset: hold RST=1 and toggle CLK -> AN=FF, SEG=7F, DP=1, FRAME=0. Assert RST asynchronously mid-slot while digit 2 is lit -> AN=FF in the same timestep, before the next edge.
2. Scan order: DISP_SEQ=32'h87654321, OFF=00, DP=00 -> AN sequence FE,FD,FB,F7,EF,DF,BF,7F, each low for 3 of 4 cycles with 1 blank cycle between digits. SEG=79,24,30,19,12,02,78,00 respectively. FRAME pulses every 32 cycles.
3. Blanking: OFF=8'hF0 -> AN stays FF and SEG stays 7F for digits 4..7. Digits 0..3 behave as in scenario 2.
4. Anti-tear: change DISP_SEQ from 32'h87654321 to 32'h00000000 while digit 3 is lit -> digits 4..7 still show 5,6,7,8. Zeros ("40") appear only after the next FRAME pulse.
5. Full decode: show 32'hFEDCBA98 for one frame, then 32'h76543210 for the next -> every SEG value matches the 16-entry table.
6. Decimal point: DISP_DP=8'h81 -> DP=0 only while AN=FE or AN=7F, and DP=1 in blank cycles. DISP_DP=8'h01 with OFF=8'h01 -> DP never low.
